// File: rtl/div_check_mult_8x8_if.sv
// div_check_mult_8x8_if: operand/result handshake bundle for the dividend reconstructor.
interface div_check_mult_8x8_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  q;
    logic [7:0]  d;
    logic [7:0]  r;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] n;
    logic        rem_err;
    logic        div_zero;
    modport master (output in_valid, q, d, r, out_ready,
                    input  in_ready, out_valid, n, rem_err, div_zero);
    modport slave  (input  in_valid, q, d, r, out_ready,
                    output in_ready, out_valid, n, rem_err, div_zero);
endinterface

// File: rtl/div_check_mult_8x8.sv
// div_check_mult_8x8: sequential shift-add reconstruction n = q*d + r, one quotient bit per cycle,
// with optional OR-combined low columns that never carry into bit APPROX_LSB.
module div_check_mult_8x8 #(
    parameter int APPROX_LSB = 0
) (
    input logic                 clk,
    input logic                 rst_n,
    div_check_mult_8x8_if.slave io
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [15:0] LOW_MASK = 16'((32'd1 << APPROX_LSB) - 32'd1);
    state_t      state_q, state_d;
    logic [7:0]  qr_q, qr_d, dr_q, dr_d;
    logic [15:0] acc_q, acc_d, n_q, n_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        rem_err_q, rem_err_d, div_zero_q, div_zero_d;
    logic [15:0] addend, sum;
    always_comb begin
        addend = qr_q[cnt_q] ? ({8'h00, dr_q} << cnt_q) : 16'h0000;
        // high columns are added with their low bits zeroed, so no carry can enter from below
        sum = ((acc_q | addend) & LOW_MASK)
            | (((acc_q & ~LOW_MASK) + (addend & ~LOW_MASK)) & ~LOW_MASK);
    end
    always_comb begin
        state_d    = state_q;
        qr_d       = qr_q;
        dr_d       = dr_q;
        acc_d      = acc_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        rem_err_d  = rem_err_q;
        div_zero_d = div_zero_q;
        case (state_q)
            IDLE: if (io.in_valid) begin
                qr_d       = io.q;
                dr_d       = io.d;
                acc_d      = {8'h00, io.r};
                cnt_d      = 3'd0;
                rem_err_d  = io.r >= io.d;
                div_zero_d = io.d == 8'd0;
                state_d    = BUSY;
            end
            BUSY: begin
                acc_d = sum;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    n_d     = sum;
                    state_d = DONE;
                end
            end
            DONE: if (io.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            qr_q       <= 8'd0;
            dr_q       <= 8'd0;
            acc_q      <= 16'd0;
            n_q        <= 16'd0;
            cnt_q      <= 3'd0;
            rem_err_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            qr_q       <= qr_d;
            dr_q       <= dr_d;
            acc_q      <= acc_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            rem_err_q  <= rem_err_d;
            div_zero_q <= div_zero_d;
        end
    end
    assign io.in_ready  = state_q == IDLE;
    assign io.out_valid = state_q == DONE;
    assign io.n         = n_q;
    assign io.rem_err   = rem_err_q;
    assign io.div_zero  = div_zero_q;
endmodule

// File: tb/tb_div_check_mult_8x8.sv
// tb_div_check_mult_8x8: drives an exact and an APPROX_LSB=4 instance in lockstep and checks both
// against arithmetic reference models.
module tb_div_check_mult_8x8;
    localparam int AL = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    div_check_mult_8x8_if ie ();
    div_check_mult_8x8_if ia ();
    div_check_mult_8x8 #(.APPROX_LSB(0))  u_exact  (.clk(clk), .rst_n(rst_n), .io(ie.slave));
    div_check_mult_8x8 #(.APPROX_LSB(AL)) u_approx (.clk(clk), .rst_n(rst_n), .io(ia.slave));
    assign ia.in_valid  = ie.in_valid;
    assign ia.q         = ie.q;
    assign ia.d         = ie.d;
    assign ia.r         = ie.r;
    assign ia.out_ready = ie.out_ready;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  q, d, r;
        logic [15:0] n;
        logic        re, dz;
    } vec_t;

    function automatic logic [15:0] approx_ref(input logic [7:0] qq, dd, rr);
        int lo, hi, a;
        lo = rr % (1 << AL);
        hi = rr / (1 << AL);
        for (int i = 0; i < 8; i++)
            if (qq[i]) begin
                a  = dd * (1 << i);
                lo = lo | (a % (1 << AL));
                hi = (hi + a / (1 << AL)) % (1 << (16 - AL));
            end
        return 16'(hi * (1 << AL) + lo);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start(input logic [7:0] qq, dd, rr, output int acc_cyc);
        check("in_ready_before_start", ie.in_ready, 1);
        ie.in_valid = 1'b1;
        ie.q = qq;
        ie.d = dd;
        ie.r = rr;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        ie.in_valid = 1'b0;
        ie.q = 8'($urandom);
        ie.d = 8'($urandom);
        ie.r = 8'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!ie.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [7:0] qq, dd, rr, input logic [15:0] en,
                          input logic ere, edz, output int acc_cyc);
        int lat;
        start(qq, dd, rr, acc_cyc);
        wait_out(lat);
        check("latency", lat, 8);
        check("n_exact", ie.n, en);
        check("rem_err", ie.rem_err, ere);
        check("div_zero", ie.div_zero, edz);
        check("approx_valid", ia.out_valid, 1);
        check("n_approx", ia.n, approx_ref(qq, dd, rr));
    endtask

    initial begin
        vec_t tbl[7];
        int   ac, prev, lat;
        logic [15:0] hold_n;
        logic hold_re, hold_dz;
        logic seen;
        logic [7:0] rq, rd, rr;
        tbl[0] = '{8'd12,  8'd10,  8'd7,   16'd127,   1'b0, 1'b0};
        tbl[1] = '{8'd255, 8'd255, 8'd254, 16'd65279, 1'b0, 1'b0};
        tbl[2] = '{8'd255, 8'd255, 8'd255, 16'd65280, 1'b1, 1'b0};
        tbl[3] = '{8'd5,   8'd0,   8'd3,   16'd3,     1'b1, 1'b1};
        tbl[4] = '{8'd0,   8'd7,   8'd3,   16'd3,     1'b0, 1'b0};
        tbl[5] = '{8'd1,   8'd1,   8'd0,   16'd1,     1'b0, 1'b0};
        tbl[6] = '{8'd128, 8'd200, 8'd250, 16'd25850, 1'b1, 1'b0};
        ie.in_valid = 1'b0;
        ie.out_ready = 1'b1;
        ie.q = 8'd0;
        ie.d = 8'd0;
        ie.r = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", ie.in_ready, 1);
        check("rst_out_valid", ie.out_valid, 0);
        check("rst_n", ie.n, 0);
        check("rst_rem_err", ie.rem_err, 0);
        check("rst_div_zero", ie.div_zero, 0);
        check("rst_n_approx", ia.n, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            run_op(tbl[i].q, tbl[i].d, tbl[i].r, tbl[i].n, tbl[i].re, tbl[i].dz, ac);
            @(posedge clk);
            #1;
            check("out_valid_drop", ie.out_valid, 0);
            check("in_ready_after", ie.in_ready, 1);
        end
        // approximate-path hand case: low nibble ORs, high part adds without carry-in
        start(8'd3, 8'd15, 8'd0, ac);
        wait_out(lat);
        check("approx_latency", lat, 8);
        check("approx_3x15", ia.n, 16'h001F);
        check("exact_3x15", ie.n, 16'd45);
        @(posedge clk);
        #1;
        // backpressure stall with ignored operands
        ie.out_ready = 1'b0;
        run_op(8'd20, 8'd11, 8'd5, 16'd225, 1'b0, 1'b0, ac);
        hold_n = ie.n;
        hold_re = ie.rem_err;
        hold_dz = ie.div_zero;
        for (int k = 0; k < 20; k++) begin
            if (k == 5) begin
                ie.in_valid = 1'b1;
                ie.q = 8'd99;
                ie.d = 8'd3;
                ie.r = 8'd9;
            end else ie.in_valid = 1'b0;
            @(posedge clk);
            #1;
            check("stall_out_valid", ie.out_valid, 1);
            check("stall_n", ie.n, hold_n);
            check("stall_rem_err", ie.rem_err, hold_re);
            check("stall_div_zero", ie.div_zero, hold_dz);
            check("stall_in_ready", ie.in_ready, 0);
        end
        ie.in_valid = 1'b0;
        ie.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_out_valid", ie.out_valid, 0);
        check("release_in_ready", ie.in_ready, 1);
        run_op(8'd3, 8'd4, 8'd1, 16'd13, 1'b0, 1'b0, ac);
        @(posedge clk);
        #1;
        // reset while BUSY with cnt=4
        start(8'd200, 8'd100, 8'd50, ac);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_out_valid", ie.out_valid, 0);
        check("abort_in_ready", ie.in_ready, 1);
        check("abort_n", ie.n, 0);
        check("abort_rem_err", ie.rem_err, 0);
        check("abort_div_zero", ie.div_zero, 0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (ie.out_valid || ia.out_valid) seen = 1'b1;
        end
        check("abort_no_output", seen, 0);
        run_op(8'd2, 8'd3, 8'd1, 16'd7, 1'b0, 1'b0, ac);
        @(posedge clk);
        #1;
        // back-to-back random operations
        prev = 0;
        for (int i = 0; i < 1000; i++) begin
            rq = 8'($urandom);
            rd = 8'($urandom);
            rr = 8'($urandom);
            if (i % 50 == 0) rd = 8'd0;
            run_op(rq, rd, rr, 16'(rq * rd + rr), rr >= rd, rd == 8'd0, ac);
            if (i > 0) check("accept_spacing", ac - prev, 10);
            prev = ac;
            @(posedge clk);
            #1;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
